sequenciador_instrucao: RTL
===========================

# sequenciador_instrucao

Instruction fetch and step sequencer that sits directly upstream of the processor control logic. It buffers instruction words from a loader in a small FIFO, holds the executing instruction in an instruction register (`iin`), and drives the 2-bit step counter (`counter`) through steps 00→01→10→11 for each instruction. The control logic latches opcode/rx/ry at step 00 and enables A, the ALU output and the destination register at steps 01, 10 and 11.

## Interface
- `IW`, default 9: instruction width, laid out as opcode[8:6], rx[5:3], ry[2:0].
- `DEPTH`, default 4: FIFO depth; must be a power of 2, minimum 2.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `din`  in  IW  instruction word from the loader.
- `din_valid`  in  1  loader offers `din` this cycle.
- `din_ready`  out  1  FIFO can accept a word; high when `fill < DEPTH`.
- `run`  in  1  permits starting a new instruction.
- `counter`  out  2  step number to the control logic.
- `iin`  out  IW  instruction register to the control logic.
- `busy`  out  1  high while an instruction is executing (state EXEC).
- `done`  out  1  high during the final step (EXEC and `counter==11`).
- `fill`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation
- **Reset (async, any time).** `counter`=00, `iin`=0, `fill`=0, read/write pointers=0, state=IDLE, `busy`=0, `done`=0, `din_ready`=1.
  - An in-flight instruction is discarded and buffered words are lost.
- **Push.** When `din_valid && din_ready` at an edge, `din` is written at the write pointer, the pointer increments and `fill` increments.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- **Pop.** Occurs only on an instruction start. The head is loaded into `iin`, the read pointer increments and `fill` decrements.
- **Simultaneous push and pop.** `fill` is unchanged and both pointers advance.
  - Push is gated only by `din_ready`, which is computed from the pre-edge `fill`. A full FIFO rejects a push even in a pop cycle.
  - There is no bypass: a word pushed at edge N cannot be popped before edge N+1.
- **FSM states.**
  - IDLE: `counter` is held at 00 and `iin` holds the last instruction. If `run && fill!=0`, pop and go to EXEC with `counter` staying at 00.
  - EXEC: `counter` increments every cycle 00→01→10→11.
    - At 11, if `run && fill!=0`: pop, `counter` wraps to 00 and the state stays EXEC (back-to-back execution).
    - Otherwise: go to IDLE with `counter`=00.
- **`run` deassertion.** Dropping `run` mid-instruction does not abort it. All four steps complete, then the FSM goes to IDLE.
- **Empty FIFO in IDLE.** No pop occurs, regardless of `run`.
- **`iin` stability.** `iin` changes only on a pop edge. It is stable for all four steps of its instruction.

## Timing
- `din_ready`, `busy`, `done` and `fill` are functions of registered state only. No input-to-output combinational path exists.
- **Start latency.** Word pushed at edge N into an empty FIFO with `run`=1:
  - pop at edge N+1;
  - `counter`=00 with `iin`=word in cycle N+1..N+2;
  - steps 01, 10, 11 after edges N+2, N+3, N+4;
  - `done`=1 in the cycle after edge N+4.
- **Throughput.** One instruction per 4 cycles when the FIFO is non-empty and `run`=1.
- **FIFO full.** `din_ready` falls in the cycle after the DEPTH-th push. It rises in the cycle after the first pop.

## Test plan
- **Reset values.** Assert `resetn`=0 mid-EXEC (counter=10) → immediately `counter`=00, `iin`=0, `busy`=0, `done`=0, `fill`=0, `din_ready`=1. The discarded instruction never reaches step 11.
- **Single instruction.** `run`=1, push 9'b101_011_000 → after one cycle `iin`=9'h158 and `busy`=1. `counter` then reads 00,01,10,11 on consecutive cycles, `done`=1 only at 11, then IDLE with `counter`=00 and `iin` still 9'h158.
- **Back-to-back.** With `run`=0, push 9'h000, 9'h04A, 9'h100; then set `run`=1 → three instructions with no IDLE cycle between them. `counter` wraps 11→00 directly and `iin` changes exactly at each wrap. `fill` goes 3,2,1,0.
- **Full / wrap-around.** `run`=0, push 5 words with `din_valid` held high → only 4 are accepted, `din_ready`=0 after the 4th and `fill`=4.
  - Set `run`=1 and push a 5th word while the first is popped → the 5th is accepted only after `din_ready` rises.
  - All 5 words execute in order across the pointer wrap.
- **`run` drop.** Deassert `run` at `counter`=01 with `fill`=2 → the instruction finishes through 11, then IDLE with `fill` still 2.
  - Reassert `run` → the next word starts one cycle later.
- **Empty stall.** `run`=1, FIFO empty for 10 cycles → `counter` stays 00 and `busy`=0. A push then yields a start on the following edge.

Source files
------------

// File: rtl/sequenciador_instrucao.sv
// Instruction fetch FIFO plus 4-step sequencer feeding iin/counter to the control logic.
// Latency: a word pushed into an empty FIFO with run=1 is popped into iin on the next edge.
// Backpressure: din_ready drops while the FIFO holds DEPTH words; a pop frees space one cycle later.
module sequenciador_instrucao #(
  parameter int IW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [IW-1:0]          din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic                   run,
  output logic [1:0]             counter,
  output logic [IW-1:0]          iin,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    counter_nxt;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] mem [DEPTH];

  // Status outputs come from registered state only; push uses the pre-edge fill.
  assign din_ready = (fill < FULL);
  assign busy      = (state == EXEC);
  assign done      = (state == EXEC) && (counter == 2'b11);
  assign push      = din_valid && din_ready;

  // Next-state and step logic; a pop happens only when an instruction starts.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        counter_nxt = 2'b00;
        if (run && (fill != '0)) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (counter == 2'b11) begin
          counter_nxt = 2'b00;
          if (run && (fill != '0)) begin
            pop = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          counter_nxt = counter + 2'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = 2'b00;
      end
    endcase
  end

  // Sequencer state and step counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      counter <= 2'b00;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  // FIFO pointers, occupancy and instruction register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      iin    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        iin    <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Storage is not reset; words beyond fill are never read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule
